xor_swap_sort_ctrl: RTL and testbench

//  Sequencer that owns a DEPTH-entry register bank and sorts it ascending (unsigned) using

---
 rtl/xor_swap_sort_ctrl.sv | 160 ++++++++++++++++
 tb/tb_xor_swap_sort_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/xor_swap_sort_ctrl.sv
// Batch sorter: loads DEPTH words, bubble-sorts them in place with 3-step XOR swaps,
// then streams the ascending result out over a valid/ready port.
module xor_swap_sort_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNTW-1:0]  swap_count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_CMP    = 3'd1,
    S_SWAP1  = 3'd2,
    S_SWAP2  = 3'd3,
    S_SWAP3  = 3'd4,
    S_UNLOAD = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr;
  logic [IW-1:0]    rd;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    last;
  logic             swapped;

  logic [IW-1:0]    idx_nx;
  logic [WIDTH-1:0] word_a;
  logic [WIDTH-1:0] word_b;
  logic             more;
  logic             last_pass;

  // idx < last always holds, so idx+1 never overflows IW bits
  assign idx_nx    = idx + IW'(1);
  assign word_a    = mem[idx];
  assign word_b    = mem[idx_nx];
  assign more      = (idx_nx < last);
  assign last_pass = (last == IW'(1));

  // Sequencer: load, compare/swap passes, unload; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      wr         <= '0;
      rd         <= '0;
      idx        <= '0;
      last       <= '0;
      swapped    <= 1'b0;
      swap_count <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            mem[wr] <= in_data;
            if (wr == '0) swap_count <= '0;
            if (wr == LAST_IDX) begin
              wr       <= '0;
              idx      <= '0;
              last     <= LAST_IDX;
              swapped  <= 1'b0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= S_CMP;
            end else begin
              wr <= wr + IW'(1);
            end
          end
        end
        S_CMP: begin
          if (word_a > word_b) begin
            state <= S_SWAP1;
          end else if (more) begin
            idx <= idx_nx;
          end else if (!swapped || last_pass) begin
            rd        <= '0;
            out_valid <= 1'b1;
            out_data  <= mem[0];
            busy      <= 1'b0;
            state     <= S_UNLOAD;
          end else begin
            last    <= last - IW'(1);
            idx     <= '0;
            swapped <= 1'b0;
          end
        end
        S_SWAP1: begin
          mem[idx] <= word_a ^ word_b;
          state    <= S_SWAP2;
        end
        S_SWAP2: begin
          mem[idx_nx] <= word_b ^ word_a;
          state       <= S_SWAP3;
        end
        S_SWAP3: begin
          mem[idx] <= word_a ^ word_b;
          swapped  <= 1'b1;
          if (swap_count != {CNTW{1'b1}}) swap_count <= swap_count + CNTW'(1);
          if (more) begin
            idx   <= idx_nx;
            state <= S_CMP;
          end else if (last_pass) begin
            // last pass is only entry 0/1, so the word being written here is the new mem[0]
            rd        <= '0;
            out_valid <= 1'b1;
            out_data  <= word_a ^ word_b;
            busy      <= 1'b0;
            state     <= S_UNLOAD;
          end else begin
            last    <= last - IW'(1);
            idx     <= '0;
            swapped <= 1'b0;
            state   <= S_CMP;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            if (rd == LAST_IDX) begin
              rd        <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              in_ready  <= 1'b1;
              state     <= S_LOAD;
            end else begin
              rd       <= rd + IW'(1);
              out_data <= mem[rd + IW'(1)];
            end
          end
        end
        default: begin
          state     <= S_LOAD;
          wr        <= '0;
          rd        <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_data  <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_swap_sort_ctrl.sv
// Self-checking bench for xor_swap_sort_ctrl: vector table, hand-written corner
// sequences and randomized batches checked against a sort/inversion-count model.
module tb_xor_swap_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       busy;
  logic [7:0] swap_count;

  int nvec = 0;
  int nerr = 0;

  xor_swap_sort_ctrl #(.WIDTH(4), .DEPTH(4), .CNTW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] din;
    logic [15:0] dout;
    logic [7:0]  swaps;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word k of a batch sits in nibble k counted from the top, so 16'h9754 means 9,7,5,4
  task automatic load(input logic [15:0] w, input bit rnd);
    int k = 0;
    int budget = 0;
    bit acc;
    while (k < 4 && budget < 200) begin
      in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = w[15-4*k -: 4];
      acc      = in_valid && in_ready;
      step();
      if (acc) k++;
      budget++;
    end
    in_valid = 1'b0;
    if (k < 4) begin
      nvec++;
      nerr++;
      $display("FAIL load_timeout: got %0d words expected 4", k);
    end
  endtask

  task automatic unload(output logic [15:0] got, input bit rnd);
    int k = 0;
    int budget = 0;
    got = 16'h0000;
    while (k < 4 && budget < 400) begin
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_valid  = !in_ready && ($urandom_range(0, 1) == 1);
      in_data   = 4'($urandom);
      if (out_valid && out_ready) begin
        got[15-4*k -: 4] = out_data;
        k++;
      end
      step();
      budget++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (k < 4) begin
      nvec++;
      nerr++;
      $display("FAIL unload_timeout: got %0d words expected 4", k);
    end
  endtask

  task automatic check_batch(input string name, input logic [15:0] got, input vec_t v);
    for (int k = 0; k < 4; k++)
      check({name, "_word"}, 32'(got[15-4*k -: 4]), 32'(v.dout[15-4*k -: 4]));
    check({name, "_swaps"}, 32'(swap_count), 32'(v.swaps));
  endtask

  // Reference: ascending sort plus inversion count (= bubble-sort exchanges)
  function automatic vec_t model(input logic [15:0] din);
    logic [3:0] w [4];
    logic [3:0] t;
    int inv = 0;
    vec_t v;
    for (int k = 0; k < 4; k++) w[k] = din[15-4*k -: 4];
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++)
        if (w[a] > w[b]) inv++;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 3 - a; b++)
        if (w[b] > w[b+1]) begin t = w[b]; w[b] = w[b+1]; w[b+1] = t; end
    v.din = din;
    for (int k = 0; k < 4; k++) v.dout[15-4*k -: 4] = w[k];
    v.swaps = (inv > 255) ? 8'hFF : 8'(inv);
    return v;
  endfunction

  initial begin
    vec_t        tbl [5];
    vec_t        v;
    logic [15:0] got;
    int          cnt;

    tbl[0] = '{din: 16'h9754, dout: 16'h4579, swaps: 8'd6};
    tbl[1] = '{din: 16'h5555, dout: 16'h5555, swaps: 8'd0};
    tbl[2] = '{din: 16'hC4D5, dout: 16'h45CD, swaps: 8'd3};
    tbl[3] = '{din: 16'h1234, dout: 16'h1234, swaps: 8'd0};
    tbl[4] = '{din: 16'h3120, dout: 16'h0123, swaps: 8'd5};

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_swap_count", 32'(swap_count), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int n = 0; n < 5; n++) begin
      load(tbl[n].din, 1'b0);
      unload(got, 1'b0);
      check_batch("table", got, tbl[n]);
    end

    // Already sorted: DEPTH-1 compare cycles, then the first word is presented
    load(16'h1234, 1'b0);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      step();
    end
    check("sorted_cmp_cycles", 32'(cnt), 32'd3);
    check("sorted_out_valid", 32'(out_valid), 32'd1);
    check("sorted_first_word", 32'(out_data), 32'd1);
    unload(got, 1'b0);
    check_batch("sorted", got, model(16'h1234));

    // Consumer stall: head word must hold
    load(16'hC4D5, 1'b0);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      cnt++;
      step();
    end
    for (int c = 0; c < 5; c++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'd4);
      step();
    end
    unload(got, 1'b0);
    check_batch("stall", got, model(16'hC4D5));

    // Reset in the middle of the first exchange (CMP -> SWAP1 -> SWAP2)
    load(16'h9754, 1'b0);
    step();
    step();
    check("swap2_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_swap_count", 32'(swap_count), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    load(16'h3120, 1'b0);
    unload(got, 1'b0);
    check_batch("after_rst", got, model(16'h3120));

    // Random batches with random handshakes, back to back
    for (int n = 0; n < 30; n++) begin
      v = model(16'($urandom));
      load(v.din, 1'b1);
      unload(got, 1'b1);
      check_batch("random", got, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
